// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator: NUM_CH channels fire the CPU interrupt when the
// macroscopic PC hits a programmed address. Optional timeout: IRQ_TIMEOUT_EN.
module irq_stim_gen #(
  parameter int                   NUM_CH   = 2,
  parameter logic [32*NUM_CH-1:0] TRIG_PC  = {32'h00003020, 32'h00003014},
  parameter logic [8*NUM_CH-1:0]  DELAY    = {8'd0, 8'd0},
  parameter int                   MAX_FIRE = 1,
  parameter logic [31:0]          ACK_ADDR = 32'h00007F20,
  parameter logic [15:0]          TIMEOUT  = 16'd256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       macroscopic_pc,
  input  logic [31:0]       m_data_addr,
  input  logic [3:0]        m_data_byteen,
  output logic              interrupt,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              all_done
`ifdef IRQ_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ASSERT, ST_RETIRED} state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [7:0]        dly_q   [NUM_CH];
  logic [7:0]        dly_d   [NUM_CH];
  logic [7:0]        fire_q  [NUM_CH];
  logic [7:0]        fire_d  [NUM_CH];
  logic [NUM_CH-1:0] pc_hit;
  logic [NUM_CH-1:0] hit_q;
  logic [NUM_CH-1:0] irq_d;
  logic [NUM_CH-1:0] done_d;
  logic [NUM_CH-1:0] irq_vec_q;
  logic              interrupt_q;
  logic              all_done_q;
  logic              ack;

`ifdef IRQ_TIMEOUT_EN
  logic [15:0] tmo_q [NUM_CH];
  logic [15:0] tmo_d [NUM_CH];
  logic        terr_q;
  logic        terr_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    ack = (|m_data_byteen) && ((m_data_addr & 32'hFFFF_FFFC) == ACK_ADDR);
    for (int i = 0; i < NUM_CH; i++) begin
      pc_hit[i] = enable && ((macroscopic_pc & 32'hFFFF_FFFC) == TRIG_PC[32*i +: 32]);
    end
  end

  // The PC comparison is registered first, so a hit sampled at edge t is acted
  // on at edge t+1 and the request rises after edge t+1+DELAY.
  always_comb begin
`ifdef IRQ_TIMEOUT_EN
    terr_d = terr_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every always_comb output gets a default before the case so no
      // path leaves it unassigned, which would otherwise infer a latch.
      state_d[i] = state_q[i];
      dly_d[i]   = dly_q[i];
      fire_d[i]  = fire_q[i];
`ifdef IRQ_TIMEOUT_EN
      tmo_d[i]   = '0;
`endif
      unique case (state_q[i])
        ST_IDLE: begin
          if (hit_q[i]) begin
            dly_d[i]   = DELAY[8*i +: 8];
            state_d[i] = (DELAY[8*i +: 8] == 8'd0) ? ST_ASSERT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dly_q[i] == 8'd1) state_d[i] = ST_ASSERT;
          else                  dly_d[i]   = dly_q[i] - 8'd1;
        end
        ST_ASSERT: begin
          if (ack) begin
            if (fire_q[i] != 8'hFF) fire_d[i] = fire_q[i] + 8'd1;
            state_d[i] = (MAX_FIRE != 0 && int'(fire_q[i]) + 1 == MAX_FIRE)
                         ? ST_RETIRED : ST_IDLE;
          end
`ifdef IRQ_TIMEOUT_EN
          else if (tmo_q[i] + 16'd1 == TIMEOUT) begin
            state_d[i] = ST_IDLE;
            terr_d     = 1'b1;
          end else begin
            tmo_d[i] = tmo_q[i] + 16'd1;
          end
`endif
        end
        default: ;
      endcase
      irq_d[i]  = (state_d[i] == ST_ASSERT);
      done_d[i] = (state_d[i] == ST_RETIRED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-channel arrays are a handful of flops, so all of them are
      // reset explicitly rather than relying on state to mask stale counters.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        dly_q[i]   <= '0;
        fire_q[i]  <= '0;
`ifdef IRQ_TIMEOUT_EN
        tmo_q[i]   <= '0;
`endif
      end
      hit_q       <= '0;
      irq_vec_q   <= '0;
      interrupt_q <= 1'b0;
      all_done_q  <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      fire_q      <= fire_d;
`ifdef IRQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
      terr_q      <= terr_d;
`endif
      hit_q       <= pc_hit;
      irq_vec_q   <= irq_d;
      interrupt_q <= |irq_d;
      all_done_q  <= &done_d;
    end
  end

  assign irq_vec   = irq_vec_q;
  assign interrupt = interrupt_q;
  assign all_done  = all_done_q;
`ifdef IRQ_TIMEOUT_EN
  assign timeout_err = terr_q;
`endif

endmodule

// File: tb/tb_irq_stim_gen.sv
// Scoreboard bench for irq_stim_gen: two instances (retiring and free-running)
// share stimulus; an event-level reference model queues expected outputs.
module tb_irq_stim_gen;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] pc, addr;
  logic [3:0]  be;
  logic [1:0]  irq_a;
  logic        int_a, done_a;
  logic [0:0]  irq_b;
  logic        int_b, done_b;
`ifdef IRQ_TIMEOUT_EN
  logic        terr_a, terr_b;
`endif

  always #5 clk = ~clk;

  irq_stim_gen #(
    .NUM_CH(2), .TRIG_PC({32'h00003020, 32'h00003014}), .DELAY({8'd3, 8'd0}),
    .MAX_FIRE(1), .ACK_ADDR(32'h00007F20), .TIMEOUT(16'd4)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .macroscopic_pc(pc),
    .m_data_addr(addr), .m_data_byteen(be),
    .interrupt(int_a), .irq_vec(irq_a), .all_done(done_a)
`ifdef IRQ_TIMEOUT_EN
    , .timeout_err(terr_a)
`endif
  );

  irq_stim_gen #(
    .NUM_CH(1), .TRIG_PC(32'h00003014), .DELAY(8'd0),
    .MAX_FIRE(0), .ACK_ADDR(32'h00007F20), .TIMEOUT(16'd4)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .macroscopic_pc(pc),
    .m_data_addr(addr), .m_data_byteen(be),
    .interrupt(int_b), .irq_vec(irq_b), .all_done(done_b)
`ifdef IRQ_TIMEOUT_EN
    , .timeout_err(terr_b)
`endif
  );

  // Channels 0,1 belong to dut_a, channel 2 to dut_b.
  localparam logic [31:0] CH_TRIG [3] = '{32'h3014, 32'h3020, 32'h3014};
  localparam int          CH_DLY  [3] = '{0, 3, 0};
  localparam int          CH_MAX  [3] = '{1, 1, 0};
  localparam int          CH_OWN  [3] = '{0, 0, 1};
  localparam int          TMO         = 4;

  typedef struct {
    logic [1:0] irq_a;
    logic       int_a, done_a, irq_b, int_b, done_b, terr_a, terr_b;
  } exp_t;
  exp_t exp_q[$];

  // Model: mode 0 idle, 1 delayed (rises at cycle rise_at), 2 requesting, 3 retired.
  int mode [3], rise_at [3], fires [3], held [3];
  bit hit_prev [3];
  bit terr [2];
  int cyc = 0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input bit r, input bit en, input logic [31:0] p,
                      input logic [31:0] a, input logic [3:0] b);
    exp_t e;
    bit   ack;
    @(negedge clk);
    reset = r; enable = en; pc = p; addr = a; be = b;
    cyc++;
    if (r) begin
      for (int c = 0; c < 3; c++) begin
        mode[c] = 0; fires[c] = 0; held[c] = 0; hit_prev[c] = 0;
      end
      terr[0] = 0; terr[1] = 0;
    end else begin
      ack = (b != 4'h0) && ((a & 32'hFFFF_FFFC) == 32'h7F20);
      for (int c = 0; c < 3; c++) begin
        case (mode[c])
          0: if (hit_prev[c]) begin
               if (CH_DLY[c] == 0) begin mode[c] = 2; held[c] = 0; end
               else begin mode[c] = 1; rise_at[c] = cyc + CH_DLY[c]; end
             end
          1: if (cyc == rise_at[c]) begin mode[c] = 2; held[c] = 0; end
          2: if (ack) begin
               fires[c] = (fires[c] < 255) ? fires[c] + 1 : 255;
               mode[c]  = (CH_MAX[c] != 0 && fires[c] == CH_MAX[c]) ? 3 : 0;
             end else begin
`ifdef IRQ_TIMEOUT_EN
               held[c]++;
               if (held[c] == TMO) begin mode[c] = 0; terr[CH_OWN[c]] = 1; end
`endif
             end
          default: ;
        endcase
        hit_prev[c] = en && ((p & 32'hFFFF_FFFC) == CH_TRIG[c]);
      end
    end
    e.irq_a  = {mode[1] == 2, mode[0] == 2};
    e.int_a  = (mode[0] == 2) || (mode[1] == 2);
    e.done_a = (mode[0] == 3) && (mode[1] == 3);
    e.irq_b  = (mode[2] == 2);
    e.int_b  = (mode[2] == 2);
    e.done_b = (mode[2] == 3);
    e.terr_a = terr[0];
    e.terr_b = terr[1];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit en);
    for (int k = 0; k < n; k++) step(1'b0, en, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
  endtask

  // Monitor: one expected entry per clock edge that followed a stimulus step.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("irq_vec_a",   32'(irq_a),  32'(e.irq_a));
      check("interrupt_a", 32'(int_a),  32'(e.int_a));
      check("all_done_a",  32'(done_a), 32'(e.done_a));
      check("irq_vec_b",   32'(irq_b),  32'(e.irq_b));
      check("interrupt_b", 32'(int_b),  32'(e.int_b));
      check("all_done_b",  32'(done_b), 32'(e.done_b));
`ifdef IRQ_TIMEOUT_EN
      check("timeout_err_a", 32'(terr_a), 32'(e.terr_a));
      check("timeout_err_b", 32'(terr_b), 32'(e.terr_b));
`endif
    end
  end

  initial begin
    logic [31:0] pcs [5];
    logic [31:0] ads [4];
    reset = 1'b1; enable = 1'b0; pc = '0; addr = '0; be = '0;
    pcs = '{32'h3014, 32'h3016, 32'h3020, 32'h3023, 32'h0};
    ads = '{32'h7F20, 32'h7F23, 32'h7F24, 32'h0};

    do_reset(3);

    // Single hit, ack with a full-word store.
    step(0, 1, 32'h3014, 32'h0, 4'h0);
    idle(4, 1);
    step(0, 1, 32'h0, 32'h7F20, 4'hF);
    idle(3, 1);

    // Delayed channel; PC wiggles and enable drop during the delay are ignored.
    step(0, 1, 32'h3020, 32'h0, 4'h0);
    step(0, 1, 32'h3014, 32'h0, 4'h0);
    step(0, 1, 32'h3020, 32'h0, 4'h0);
    step(0, 0, 32'h3020, 32'h0, 4'h0);
    idle(4, 1);
    step(0, 1, 32'h0, 32'h7F22, 4'b0100);
    idle(3, 1);

    // Both channels requesting, one sub-word ack clears both.
    do_reset(2);
    step(0, 1, 32'h3014, 32'h0, 4'h0);
    idle(2, 1);
    step(0, 1, 32'h3020, 32'h0, 4'h0);
    idle(6, 1);
    step(0, 1, 32'h0, 32'h7F22, 4'b0100);
    idle(3, 1);

    // PC parked on the trigger, periodic acks, stray store to a neighbour word.
    do_reset(2);
    for (int k = 0; k < 30; k++) begin
      if (k % 5 == 4)      step(0, 1, 32'h3014, 32'h7F20, 4'hF);
      else if (k % 7 == 3) step(0, 1, 32'h3014, 32'h7F24, 4'hF);
      else                 step(0, 1, 32'h3014, 32'h0, 4'h0);
    end

    // Reset during the delay and during a request; hits with enable low.
    do_reset(2);
    step(0, 1, 32'h3020, 32'h0, 4'h0);
    idle(2, 1);
    step(1, 1, 32'h0, 32'h0, 4'h0);
    idle(1, 1);
    step(0, 1, 32'h3014, 32'h0, 4'h0);
    idle(2, 1);
    step(1, 1, 32'h0, 32'h0, 4'h0);
    idle(2, 1);
    step(0, 0, 32'h3014, 32'h0, 4'h0);
    idle(3, 0);

    // Long request without ack, then re-arm.
    do_reset(1);
    step(0, 1, 32'h3014, 32'h0, 4'h0);
    idle(12, 1);
    step(0, 1, 32'h3014, 32'h0, 4'h0);
    idle(6, 1);

    // Randomized traffic.
    do_reset(1);
    for (int k = 0; k < 500; k++) begin
      logic [31:0] p, a;
      logic [3:0]  b;
      int          pi, ai;
      pi = $urandom_range(0, 5);
      ai = $urandom_range(0, 4);
      p  = (pi == 5) ? 32'($urandom) : pcs[pi];
      a  = (ai == 4) ? 32'($urandom) : ads[ai];
      b  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, p, a, b);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
